// File: rtl/cache_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cache_port_arbiter
// Description : Two-requester round-robin arbiter in front of a single cache
//               processor port. It keeps at most one transaction outstanding.
//               A read holds the port until the data returns. If the data does
//               not return in time, a watchdog completes the read with zero
//               data instead.
// Ports       : clk, rst              - clock, async active-high reset
//               i_r{0,1}_*            - requester address/byte-en/data/rd/wr
//               o_r{0,1}_*            - requester readdata/valid/waitrequest
//               o_c_*                 - cache-side request outputs
//               i_c_*                 - cache-side response inputs
//               o_owner, o_timeout    - current/last owner, watchdog pulse
//               cnt_g0, cnt_g1        - accepted transaction counters
// Revision    : 1.0 - initial release
// ============================================================================
module cache_port_arbiter #(
    parameter int ADDR_W     = 25,
    parameter int RD_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [ADDR_W-1:0] i_r0_addr,
    input  logic [3:0]        i_r0_byte_en,
    input  logic [31:0]       i_r0_writedata,
    input  logic              i_r0_read,
    input  logic              i_r0_write,
    output logic [31:0]       o_r0_readdata,
    output logic              o_r0_readdata_valid,
    output logic              o_r0_waitrequest,

    input  logic [ADDR_W-1:0] i_r1_addr,
    input  logic [3:0]        i_r1_byte_en,
    input  logic [31:0]       i_r1_writedata,
    input  logic              i_r1_read,
    input  logic              i_r1_write,
    output logic [31:0]       o_r1_readdata,
    output logic              o_r1_readdata_valid,
    output logic              o_r1_waitrequest,

    output logic [ADDR_W-1:0] o_c_addr,
    output logic [3:0]        o_c_byte_en,
    output logic [31:0]       o_c_writedata,
    output logic              o_c_read,
    output logic              o_c_write,
    input  logic [31:0]       i_c_readdata,
    input  logic              i_c_readdata_valid,
    input  logic              i_c_waitrequest,

    output logic              o_owner,
    output logic              o_timeout,
    output logic [31:0]       cnt_g0,
    output logic [31:0]       cnt_g1
);

    // Timer is just wide enough to reach RD_TIMEOUT; with the watchdog
    // disabled it still exists but never triggers anything.
    localparam int                 c_TMR_W   = (RD_TIMEOUT > 0) ? $clog2(RD_TIMEOUT + 1) : 1;
    localparam logic [c_TMR_W-1:0] c_TMR_MAX = c_TMR_W'(RD_TIMEOUT);
    localparam logic               c_TMO_EN  = (RD_TIMEOUT > 0);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BUSY    = 2'd1,
        S_WAIT_RD = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic                 r_owner;
    logic                 r_last_grant;
    logic [c_TMR_W-1:0]   r_timer;
    logic [31:0]          r_cnt_g0;
    logic [31:0]          r_cnt_g1;

    logic                 w_pend0;
    logic                 w_pend1;
    logic                 w_grant_sel;
    logic [ADDR_W-1:0]    w_own_addr;
    logic [3:0]           w_own_byte_en;
    logic [31:0]          w_own_writedata;
    logic                 w_own_read;
    logic                 w_own_write;
    logic                 w_own_pend;
    logic                 w_accept;
    logic                 w_rd_valid;
    logic                 w_tmo;
    logic                 w_done;

    // ------------------------------------------------------------------
    // Request decode and arbitration
    // ------------------------------------------------------------------
    assign w_pend0 = i_r0_read | i_r0_write;
    assign w_pend1 = i_r1_read | i_r1_write;

    // On a tie, the requester that was not granted last wins. Otherwise the
    // single pending requester wins.
    assign w_grant_sel = (w_pend0 && w_pend1) ? ~r_last_grant : w_pend1;

    assign w_own_addr      = r_owner ? i_r1_addr      : i_r0_addr;
    assign w_own_byte_en   = r_owner ? i_r1_byte_en   : i_r0_byte_en;
    assign w_own_writedata = r_owner ? i_r1_writedata : i_r0_writedata;
    assign w_own_read      = r_owner ? i_r1_read      : i_r0_read;
    assign w_own_write     = r_owner ? i_r1_write     : i_r0_write;
    assign w_own_pend      = w_own_read | w_own_write;

    // Read completion: real data takes priority over the watchdog.
    assign w_rd_valid = (r_state == S_WAIT_RD) && i_c_readdata_valid;
    assign w_tmo      = c_TMO_EN && (r_state == S_WAIT_RD) && !i_c_readdata_valid
                        && (r_timer == c_TMR_MAX);
    assign w_done     = w_rd_valid | w_tmo;

    // Read data passes straight through except on a forced completion.
    assign o_r0_readdata = w_tmo ? 32'd0 : i_c_readdata;
    assign o_r1_readdata = w_tmo ? 32'd0 : i_c_readdata;

    assign o_owner   = r_owner;
    assign o_timeout = w_tmo;
    assign cnt_g0    = r_cnt_g0;
    assign cnt_g1    = r_cnt_g1;

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next              = r_state;
        w_accept            = 1'b0;
        o_c_addr            = '0;
        o_c_byte_en         = 4'd0;
        o_c_writedata       = 32'd0;
        o_c_read            = 1'b0;
        o_c_write           = 1'b0;
        o_r0_waitrequest    = 1'b1;
        o_r1_waitrequest    = 1'b1;
        o_r0_readdata_valid = 1'b0;
        o_r1_readdata_valid = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_pend0 || w_pend1) begin
                    w_next = S_BUSY;
                end
            end

            S_BUSY: begin
                o_c_addr      = w_own_addr;
                o_c_byte_en   = w_own_byte_en;
                o_c_writedata = w_own_writedata;
                // Read and write together are treated as a write.
                o_c_write     = w_own_write;
                o_c_read      = w_own_read & ~w_own_write;
                if (r_owner) begin
                    o_r1_waitrequest = i_c_waitrequest;
                end else begin
                    o_r0_waitrequest = i_c_waitrequest;
                end

                if (!w_own_pend) begin
                    w_next = S_IDLE;
                end else if (!i_c_waitrequest) begin
                    w_accept = 1'b1;
                    w_next   = w_own_write ? S_IDLE : S_WAIT_RD;
                end
            end

            S_WAIT_RD: begin
                if (w_done) begin
                    if (r_owner) begin
                        o_r1_readdata_valid = 1'b1;
                    end else begin
                        o_r0_readdata_valid = 1'b1;
                    end
                    w_next = S_IDLE;
                end
            end

            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register and bookkeeping
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
            r_timer      <= '0;
            r_cnt_g0     <= 32'd0;
            r_cnt_g1     <= 32'd0;
        end else begin
            if ((r_state == S_IDLE) && (w_pend0 || w_pend1)) begin
                r_owner <= w_grant_sel;
            end

            if (w_accept) begin
                r_last_grant <= r_owner;
                if (r_owner) begin
                    r_cnt_g1 <= r_cnt_g1 + 32'd1;
                end else begin
                    r_cnt_g0 <= r_cnt_g0 + 32'd1;
                end
            end

            // The timer counts WAIT_RD cycles and restarts from zero on every entry.
            if ((r_state == S_WAIT_RD) && (w_next == S_WAIT_RD)) begin
                r_timer <= r_timer + c_TMR_W'(1);
            end else begin
                r_timer <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cache_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_port_arbiter
// Description : Directed self-checking bench for cache_port_arbiter. It runs
//               with the watchdog set to 4 cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_port_arbiter;

    localparam int ADDR_W = 25;

    logic              clk = 1'b0;
    logic              rst;
    logic [ADDR_W-1:0] i_r0_addr, i_r1_addr;
    logic [3:0]        i_r0_byte_en, i_r1_byte_en;
    logic [31:0]       i_r0_writedata, i_r1_writedata;
    logic              i_r0_read, i_r0_write, i_r1_read, i_r1_write;
    logic [31:0]       o_r0_readdata, o_r1_readdata;
    logic              o_r0_readdata_valid, o_r1_readdata_valid;
    logic              o_r0_waitrequest, o_r1_waitrequest;
    logic [ADDR_W-1:0] o_c_addr;
    logic [3:0]        o_c_byte_en;
    logic [31:0]       o_c_writedata;
    logic              o_c_read, o_c_write;
    logic [31:0]       i_c_readdata;
    logic              i_c_readdata_valid, i_c_waitrequest;
    logic              o_owner, o_timeout;
    logic [31:0]       cnt_g0, cnt_g1;

    int n_assert = 0;
    int n_fail   = 0;

    cache_port_arbiter #(
        .ADDR_W     (ADDR_W),
        .RD_TIMEOUT (4)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .i_r0_addr           (i_r0_addr),
        .i_r0_byte_en        (i_r0_byte_en),
        .i_r0_writedata      (i_r0_writedata),
        .i_r0_read           (i_r0_read),
        .i_r0_write          (i_r0_write),
        .o_r0_readdata       (o_r0_readdata),
        .o_r0_readdata_valid (o_r0_readdata_valid),
        .o_r0_waitrequest    (o_r0_waitrequest),
        .i_r1_addr           (i_r1_addr),
        .i_r1_byte_en        (i_r1_byte_en),
        .i_r1_writedata      (i_r1_writedata),
        .i_r1_read           (i_r1_read),
        .i_r1_write          (i_r1_write),
        .o_r1_readdata       (o_r1_readdata),
        .o_r1_readdata_valid (o_r1_readdata_valid),
        .o_r1_waitrequest    (o_r1_waitrequest),
        .o_c_addr            (o_c_addr),
        .o_c_byte_en         (o_c_byte_en),
        .o_c_writedata       (o_c_writedata),
        .o_c_read            (o_c_read),
        .o_c_write           (o_c_write),
        .i_c_readdata        (i_c_readdata),
        .i_c_readdata_valid  (i_c_readdata_valid),
        .i_c_waitrequest     (i_c_waitrequest),
        .o_owner             (o_owner),
        .o_timeout           (o_timeout),
        .cnt_g0              (cnt_g0),
        .cnt_g1              (cnt_g1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; checks follow 1 time unit later.
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        cyc();
        rst = 1'b1;
        settle();
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        i_r0_addr = '0; i_r0_byte_en = 4'd0; i_r0_writedata = 32'd0;
        i_r0_read = 1'b0; i_r0_write = 1'b0;
        i_r1_addr = '0; i_r1_byte_en = 4'd0; i_r1_writedata = 32'd0;
        i_r1_read = 1'b0; i_r1_write = 1'b0;
        i_c_readdata = 32'd0; i_c_readdata_valid = 1'b0; i_c_waitrequest = 1'b0;

        // ---------------- reset state ----------------
        #2;
        chk("rst_owner",   {31'd0, o_owner}, 32'd0);
        chk("rst_cnt0",    cnt_g0, 32'd0);
        chk("rst_cnt1",    cnt_g1, 32'd0);
        chk("rst_c_rw",    {30'd0, o_c_read, o_c_write}, 32'd0);
        chk("rst_c_addr",  {7'd0, o_c_addr}, 32'd0);
        chk("rst_c_wdata", o_c_writedata, 32'd0);
        chk("rst_c_be",    {28'd0, o_c_byte_en}, 32'd0);
        chk("rst_wreq",    {30'd0, o_r0_waitrequest, o_r1_waitrequest}, 32'd3);
        chk("rst_valid",   {30'd0, o_r0_readdata_valid, o_r1_readdata_valid}, 32'd0);
        chk("rst_tmo",     {31'd0, o_timeout}, 32'd0);
        cyc();
        rst = 1'b0;

        // ---------------- single write by r0 ----------------
        cyc();
        i_r0_write = 1'b1; i_r0_addr = 25'h10; i_r0_writedata = 32'hA5A5A5A5;
        i_r0_byte_en = 4'hF; i_c_waitrequest = 1'b0;
        settle();
        chk("wr_idle_cwrite", {31'd0, o_c_write}, 32'd0);
        chk("wr_idle_wreq0",  {31'd0, o_r0_waitrequest}, 32'd1);
        cyc();
        settle();
        chk("wr_cwrite", {31'd0, o_c_write}, 32'd1);
        chk("wr_cread",  {31'd0, o_c_read}, 32'd0);
        chk("wr_addr",   {7'd0, o_c_addr}, 32'h10);
        chk("wr_data",   o_c_writedata, 32'hA5A5A5A5);
        chk("wr_be",     {28'd0, o_c_byte_en}, 32'hF);
        chk("wr_wreq0",  {31'd0, o_r0_waitrequest}, 32'd0);
        chk("wr_wreq1",  {31'd0, o_r1_waitrequest}, 32'd1);
        chk("wr_cnt0_pre", cnt_g0, 32'd0);
        cyc();
        i_r0_write = 1'b0;
        settle();
        chk("wr_cnt0",    cnt_g0, 32'd1);
        chk("wr_done_cw", {31'd0, o_c_write}, 32'd0);
        chk("wr_done_wq", {31'd0, o_r0_waitrequest}, 32'd1);

        // ---------------- simultaneous reads, round robin ----------------
        do_reset();
        i_r0_read = 1'b1; i_r0_addr = 25'h100;
        i_r1_read = 1'b1; i_r1_addr = 25'h200;
        i_c_waitrequest = 1'b0;
        cyc();
        settle();
        chk("rr1_owner", {31'd0, o_owner}, 32'd0);
        chk("rr1_addr",  {7'd0, o_c_addr}, 32'h100);
        chk("rr1_cread", {31'd0, o_c_read}, 32'd1);
        chk("rr1_wreq",  {30'd0, o_r0_waitrequest, o_r1_waitrequest}, 32'd1);
        cyc();
        i_r0_read = 1'b0;
        i_c_readdata = 32'hAAAA0000; i_c_readdata_valid = 1'b1;
        settle();
        chk("rr1_wait_cread", {31'd0, o_c_read}, 32'd0);
        chk("rr1_wait_wreq",  {30'd0, o_r0_waitrequest, o_r1_waitrequest}, 32'd3);
        chk("rr1_valid",      {30'd0, o_r0_readdata_valid, o_r1_readdata_valid}, 32'd2);
        chk("rr1_rdata",      o_r0_readdata, 32'hAAAA0000);
        chk("rr1_cnt0",       cnt_g0, 32'd1);
        cyc();
        i_c_readdata_valid = 1'b0;
        cyc();
        settle();
        chk("rr2_owner", {31'd0, o_owner}, 32'd1);
        chk("rr2_addr",  {7'd0, o_c_addr}, 32'h200);
        chk("rr2_wreq",  {30'd0, o_r0_waitrequest, o_r1_waitrequest}, 32'd2);
        cyc();
        i_r1_read = 1'b0;
        i_c_readdata = 32'hBBBB0000; i_c_readdata_valid = 1'b1;
        settle();
        chk("rr2_valid", {30'd0, o_r0_readdata_valid, o_r1_readdata_valid}, 32'd1);
        chk("rr2_rdata", o_r1_readdata, 32'hBBBB0000);
        chk("rr2_cnt1",  cnt_g1, 32'd1);
        cyc();
        i_c_readdata_valid = 1'b0;
        i_r0_read = 1'b1; i_r1_read = 1'b1;
        cyc();
        settle();
        chk("rr3_owner", {31'd0, o_owner}, 32'd0);
        // Withdraw while in BUSY: no count, no grant history change.
        i_r0_read = 1'b0; i_r1_read = 1'b0;
        cyc();
        settle();
        chk("wd_cnt0", cnt_g0, 32'd1);
        chk("wd_cnt1", cnt_g1, 32'd1);
        chk("wd_wreq", {30'd0, o_r0_waitrequest, o_r1_waitrequest}, 32'd3);
        i_r0_read = 1'b1; i_r1_read = 1'b1;
        cyc();
        settle();
        chk("wd_owner", {31'd0, o_owner}, 32'd0);
        i_r0_read = 1'b0; i_r1_read = 1'b0;
        cyc();

        // ---------------- r1 read with cache stalls ----------------
        do_reset();
        i_r1_read = 1'b1; i_r1_addr = 25'h300; i_c_waitrequest = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc();
            settle();
            chk("st_cread", {31'd0, o_c_read}, 32'd1);
            chk("st_wreq",  {30'd0, o_r0_waitrequest, o_r1_waitrequest}, 32'd3);
        end
        cyc();
        i_c_waitrequest = 1'b0;
        settle();
        chk("st_accept_wreq", {30'd0, o_r0_waitrequest, o_r1_waitrequest}, 32'd2);
        cyc();
        i_r1_read = 1'b0;
        settle();
        chk("st_wait_valid", {30'd0, o_r0_readdata_valid, o_r1_readdata_valid}, 32'd0);
        chk("st_wait_wreq0", {31'd0, o_r0_waitrequest}, 32'd1);
        cyc();
        i_c_readdata = 32'h12345678; i_c_readdata_valid = 1'b1;
        settle();
        chk("st_valid", {30'd0, o_r0_readdata_valid, o_r1_readdata_valid}, 32'd1);
        chk("st_rdata", o_r1_readdata, 32'h12345678);
        chk("st_wreq0", {31'd0, o_r0_waitrequest}, 32'd1);
        chk("st_tmo",   {31'd0, o_timeout}, 32'd0);
        cyc();
        i_c_readdata_valid = 1'b0;
        settle();
        chk("st_after_valid", {30'd0, o_r0_readdata_valid, o_r1_readdata_valid}, 32'd0);
        chk("st_cnt1", cnt_g1, 32'd1);

        // ---------------- read watchdog (4 cycles) ----------------
        i_r0_read = 1'b1; i_r0_addr = 25'h40; i_c_waitrequest = 1'b0;
        i_c_readdata = 32'hDEADBEEF;
        cyc();
        cyc();
        i_r0_read = 1'b0;
        for (int k = 0; k < 4; k++) begin
            settle();
            chk("to_wait_tmo",   {31'd0, o_timeout}, 32'd0);
            chk("to_wait_valid", {30'd0, o_r0_readdata_valid, o_r1_readdata_valid}, 32'd0);
            cyc();
        end
        settle();
        chk("to_tmo",   {31'd0, o_timeout}, 32'd1);
        chk("to_valid", {30'd0, o_r0_readdata_valid, o_r1_readdata_valid}, 32'd2);
        chk("to_rdata", o_r0_readdata, 32'd0);
        cyc();
        i_c_readdata_valid = 1'b1;
        settle();
        chk("to_spurious_valid", {30'd0, o_r0_readdata_valid, o_r1_readdata_valid}, 32'd0);
        chk("to_after_tmo",      {31'd0, o_timeout}, 32'd0);
        chk("to_passthru",       o_r0_readdata, 32'hDEADBEEF);
        cyc();
        i_c_readdata_valid = 1'b0;

        // ---------------- reset during WAIT_RD ----------------
        i_r0_read = 1'b1;
        cyc();
        cyc();
        i_r0_read = 1'b0;
        rst = 1'b1;
        settle();
        chk("rw_cnt0",  cnt_g0, 32'd0);
        chk("rw_cnt1",  cnt_g1, 32'd0);
        chk("rw_wreq",  {30'd0, o_r0_waitrequest, o_r1_waitrequest}, 32'd3);
        chk("rw_owner", {31'd0, o_owner}, 32'd0);
        cyc();
        rst = 1'b0;
        cyc();
        cyc();
        i_c_readdata = 32'h0BADF00D; i_c_readdata_valid = 1'b1;
        settle();
        chk("rw_late_valid", {30'd0, o_r0_readdata_valid, o_r1_readdata_valid}, 32'd0);
        chk("rw_late_cnt",   cnt_g0 | cnt_g1, 32'd0);
        cyc();
        i_c_readdata_valid = 1'b0;

        // ---------------- read+write treated as write ----------------
        i_r1_read = 1'b1; i_r1_write = 1'b1; i_r1_addr = 25'h55;
        i_r1_writedata = 32'hCAFEF00D;
        cyc();
        settle();
        chk("rw_as_wr_cwrite", {31'd0, o_c_write}, 32'd1);
        chk("rw_as_wr_cread",  {31'd0, o_c_read}, 32'd0);
        chk("rw_as_wr_wdata",  o_c_writedata, 32'hCAFEF00D);
        cyc();
        i_r1_read = 1'b0; i_r1_write = 1'b0;
        i_r0_write = 1'b1; i_r0_addr = 25'h66;
        settle();
        chk("rw_as_wr_cnt1", cnt_g1, 32'd1);
        cyc();
        settle();
        chk("rw_as_wr_idle_next", {30'd0, o_r0_waitrequest, o_r1_waitrequest}, 32'd1);
        chk("rw_as_wr_owner",     {31'd0, o_owner}, 32'd0);
        cyc();
        i_r0_write = 1'b0;
        settle();
        chk("rw_as_wr_cnt0", cnt_g0, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
